// File: rtl/apb_multi_bridge.sv
// rtl/apb_multi_bridge.sv - APB master bridge driving one shared bus to NUM_SLAVES slaves
module apb_multi_bridge #(
    parameter int NUM_SLAVES   = 3,
    parameter int SLV_ID_WIDTH = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             newd,
    input  logic                             wr,
    input  logic [SLV_ID_WIDTH-1:0]          slv_id,
    input  logic [ADDR_WIDTH-1:0]            addrin,
    input  logic [DATA_WIDTH-1:0]            datain,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_in,
    input  logic [NUM_SLAVES-1:0]            pready_in,
    input  logic [NUM_SLAVES-1:0]            pslverr_in,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic                             pwrite,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic [DATA_WIDTH-1:0]            dataout,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             slverr_o,
    output logic                             timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    state_t                    state_q, state_d;
    logic                      wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [SLV_ID_WIDTH-1:0]   id_q, id_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      slverr_q, slverr_d;
    logic                      timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic                      sel_ready;
    logic                      sel_err;
    logic [DATA_WIDTH-1:0]     sel_rdata;

    // Only the latched target's response is looked at; all other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (id_q == SLV_ID_WIDTH'(i)) begin
                sel_ready = pready_in[i];
                sel_err   = pslverr_in[i];
                sel_rdata = prdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        psel = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                psel[i] = (id_q == SLV_ID_WIDTH'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        slverr_d  = slverr_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (newd) begin
                    wr_d    = wr;
                    addr_d  = addrin;
                    wdata_d = datain;
                    id_d    = slv_id;
                    state_d = (32'(slv_id) < NUM_SLAVES) ? SETUP : DECERR;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    slverr_d  = sel_err;
                    timeout_d = 1'b0;
                    if (!wr_q && !sel_err) begin
                        rdata_d = sel_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECERR: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                slverr_d  = 1'b1;
                timeout_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
        end
    end

    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign pwrite    = wr_q;
    assign penable   = (state_q == ACCESS);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign slverr_o  = slverr_q;
    assign timeout_o = timeout_q;
    assign dataout   = rdata_q;

endmodule

// File: tb/tb_apb_multi_bridge.sv
// tb/tb_apb_multi_bridge.sv - directed vector bench for apb_multi_bridge
module tb_apb_multi_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        newd;
    logic        wr;
    logic [1:0]  slv_id;
    logic [7:0]  addrin;
    logic [31:0] datain;
    logic [95:0] prdata_in;
    logic [2:0]  pready_in;
    logic [2:0]  pslverr_in;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] dataout;
    logic        busy_o;
    logic        done_o;
    logic        slverr_o;
    logic        timeout_o;

    apb_multi_bridge #(
        .NUM_SLAVES(3), .SLV_ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .preset(preset), .newd(newd), .wr(wr), .slv_id(slv_id),
        .addrin(addrin), .datain(datain), .prdata_in(prdata_in), .pready_in(pready_in),
        .pslverr_in(pslverr_in), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .dataout(dataout), .busy_o(busy_o),
        .done_o(done_o), .slverr_o(slverr_o), .timeout_o(timeout_o)
    );

    always #5 pclk = ~pclk;

    // waits: ACCESS cycles before the target raises pready (99 = never)
    typedef struct {
        logic        wr;
        logic [1:0]  id;
        logic [7:0]  addr;
        logic [31:0] data;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        logic        exp_err;
        logic        exp_tmo;
        logic [31:0] exp_dout;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t tbl[10];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic poke   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request at the current negedge and plays the target slave until done_o.
    task automatic run_vec(input vec_t v);
        int         cyc;
        int         acc;
        int         psel_bad;
        logic       got;
        logic [2:0] one;
        logic [2:0] psel_or;
        one        = (v.id < 2'd3) ? (3'b001 << v.id) : 3'b000;
        n_vec++;
        newd       = 1'b1;
        wr         = v.wr;
        slv_id     = v.id;
        addrin     = v.addr;
        datain     = v.data;
        pready_in  = 3'b111;
        pslverr_in = 3'b111;
        prdata_in  = {3{32'hBAD0BAD0}};
        if (v.id < 2'd3) begin
            pready_in[v.id]            = 1'b0;
            pslverr_in[v.id]           = v.err;
            prdata_in[v.id*32 +: 32]   = v.rdata;
        end
        cyc = 0; acc = 0; got = 1'b0; psel_or = 3'b000; psel_bad = 0;
        while (!got && cyc < 40) begin
            @(posedge pclk);
            @(negedge pclk);
            newd = 1'b0;
            cyc++;
            if (done_o) begin
                got = 1'b1;
            end else begin
                psel_or = psel_or | psel;
                if (psel != 3'b000 && psel != one) psel_bad++;
                if (penable && v.id < 2'd3 && psel[v.id]) begin
                    pready_in[v.id] = (acc == v.waits);
                    acc++;
                    if (poke) begin
                        newd   = 1'b1;
                        wr     = ~v.wr;
                        slv_id = 2'd2;
                        addrin = 8'hEE;
                    end
                end else if (v.id < 2'd3) begin
                    pready_in[v.id] = 1'b0;
                end
            end
        end
        if (!got) begin
            n_fail++;
            $display("FAIL done_wait: got no done_o after %0d cycles expected %0d", cyc, v.exp_lat);
        end
        chk("latency",   64'(cyc),      64'(v.exp_lat));
        chk("access_n",  64'(acc),      64'(v.exp_acc));
        chk("psel_seen", 64'(psel_or),  64'(one));
        chk("psel_bad",  64'(psel_bad), 64'd0);
        chk("slverr",    64'(slverr_o), 64'(v.exp_err));
        chk("timeout",   64'(timeout_o), 64'(v.exp_tmo));
        chk("dataout",   64'(dataout),  64'(v.exp_dout));
        chk("paddr",     64'(paddr),    64'(v.addr));
        chk("pwdata",    64'(pwdata),   64'(v.data));
        chk("pwrite",    64'(pwrite),   64'(v.wr));
        chk("idle_bus",  64'({psel, penable, busy_o}), 64'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{1'b1, 2'd0, 8'h10, 32'hDEADBEEF, 0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        3,  1};
        tbl[1] = '{1'b0, 2'd1, 8'h20, 32'h0,        2,  1'b0, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 5,  3};
        tbl[2] = '{1'b0, 2'd2, 8'h30, 32'h0,        0,  1'b1, 32'hFFFF0000, 1'b1, 1'b0, 32'h12345678, 3,  1};
        tbl[3] = '{1'b1, 2'd3, 8'h40, 32'h0000CAFE, 0,  1'b0, 32'h0,        1'b1, 1'b0, 32'h12345678, 2,  0};
        tbl[4] = '{1'b0, 2'd0, 8'h50, 32'h0,        99, 1'b0, 32'h77777777, 1'b1, 1'b1, 32'h12345678, 18, 16};
        tbl[5] = '{1'b0, 2'd0, 8'h54, 32'h0,        15, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 18, 16};
        tbl[6] = '{1'b1, 2'd2, 8'h60, 32'h01020304, 1,  1'b0, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5, 4,  2};
        tbl[7] = '{1'b0, 2'd3, 8'h70, 32'h0,        0,  1'b0, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5, 2,  0};
        tbl[8] = '{1'b0, 2'd2, 8'h64, 32'h0,        1,  1'b0, 32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 4,  2};
        tbl[9] = '{1'b0, 2'd1, 8'h24, 32'h0,        0,  1'b0, 32'h11223344, 1'b0, 1'b0, 32'h11223344, 3,  1};

        preset = 1'b1; newd = 1'b0; wr = 1'b0; slv_id = 2'd0; addrin = 8'h0; datain = 32'h0;
        prdata_in = '0; pready_in = 3'b000; pslverr_in = 3'b000;
        #1;
        n_vec++;
        chk("reset_outs", 64'({psel, penable, busy_o, done_o, slverr_o, timeout_o, pwrite}), 64'd0);
        chk("reset_data", 64'({paddr, pwdata, dataout}), 64'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // Consecutive calls issue newd in the done_o cycle, so the table runs back-to-back.
        for (int i = 0; i < 10; i++) begin
            if (i > 0) chk("b2b_done", 64'(done_o), 64'd1);
            run_vec(tbl[i]);
        end

        // newd pulsed throughout ACCESS must be ignored
        poke = 1'b1;
        run_vec('{1'b0, 2'd1, 8'h80, 32'h0, 3, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 32'h55AA55AA, 6, 4});
        poke = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("poke_idle", 64'({busy_o, psel, done_o}), 64'd0);

        // Async reset in the middle of ACCESS
        n_vec++;
        newd = 1'b1; wr = 1'b0; slv_id = 2'd1; addrin = 8'h33; pready_in = 3'b000;
        @(posedge pclk); @(negedge pclk);
        newd = 1'b0;
        @(posedge pclk); @(negedge pclk);
        chk("pre_rst_access", 64'({psel, penable, busy_o}), 64'b010_1_1);
        #2 preset = 1'b1;
        #1;
        chk("rst_bus", 64'({psel, penable, busy_o, done_o}), 64'd0);
        chk("rst_regs", 64'({dataout, paddr, slverr_o, timeout_o}), 64'd0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_idle", 64'({busy_o, done_o, psel}), 64'd0);
        run_vec('{1'b0, 2'd1, 8'h90, 32'h0, 0, 1'b0, 32'h00001111, 1'b0, 1'b0, 32'h00001111, 3, 1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_multi_bridge.md
Name: apb_multi_bridge

Overview:
- Parametrised APB master bridge driving one shared APB bus to NUM_SLAVES slaves.
- Takes the same single-request interface (newd/wr/addr/data/slave id) as the current one-slave wrapper.
- Decodes the slave id into a one-hot psel vector and muxes each slave's prdata/pready/pslverr back to the bridge.
- Adds wait-state support, an access timeout, decode errors for unmapped ids, and a completion pulse. It sits between the test/CPU-side request logic and the APB slave array.

Parameters:
- NUM_SLAVES, 3, number of attached slaves; valid ids are 0..NUM_SLAVES-1.
- SLV_ID_WIDTH, 2, width of slave id input.
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles before abort (>=1).

Ports:
- pclk  input  1  APB clock.
- preset  input  1  asynchronous active-high reset.
- newd  input  1  request strobe; sampled only when busy_o=0.
- wr  input  1  1=write, 0=read.
- slv_id  input  SLV_ID_WIDTH  target slave id.
- addrin  input  ADDR_WIDTH  transfer address.
- datain  input  DATA_WIDTH  write data.
- prdata_in  input  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- pready_in  input  NUM_SLAVES  per-slave pready.
- pslverr_in  input  NUM_SLAVES  per-slave pslverr.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pwrite  output  1  APB direction.
- psel  output  NUM_SLAVES  one-hot APB select.
- penable  output  1  APB enable.
- dataout  output  DATA_WIDTH  last successful read data.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle completion pulse.
- slverr_o  output  1  error status of the completed transfer; valid with done_o.
- timeout_o  output  1  completed transfer was aborted by timeout; valid with done_o.

Behaviour:
- Reset (async, preset=1): state IDLE; every output 0 immediately, including mid-transfer; wait counter 0.
- FSM states are IDLE, SETUP, ACCESS and DECERR.
- IDLE: busy_o=0; psel=0; penable=0.
  - newd=1: latch wr/addrin/datain/slv_id; drive paddr/pwdata/pwrite from the latched values.
  - slv_id < NUM_SLAVES: go to SETUP.
  - slv_id >= NUM_SLAVES: go to DECERR.
- SETUP (exactly 1 cycle): psel[id]=1, penable=0, busy_o=1; go to ACCESS; clear wait counter.
- ACCESS: psel[id]=1, penable=1, busy_o=1. Only the selected slave's pready/pslverr/prdata are observed; other slaves' inputs are ignored.
  - pready_in[id]=1: transfer completes; go to IDLE.
  - pready_in[id]=0 and counter==TIMEOUT-1: abort; go to IDLE with timeout.
  - otherwise: counter+1, stay in ACCESS. ACCESS therefore lasts at most TIMEOUT cycles; pready in the last allowed cycle counts as success.
- DECERR (1 cycle): busy_o=1; psel=0; penable=0; no bus activity; go to IDLE.
- Completion (registered, in the first IDLE cycle after the transfer):
  - done_o=1 for one cycle.
  - slverr_o = pslverr_in[id] sampled with pready, or 1 on timeout or decode error.
  - timeout_o=1 only on timeout.
  - slverr_o and timeout_o hold until the next done_o.
- dataout: updated only on a read that completes with pready=1 and pslverr=0. Writes, errors, timeouts and decode errors leave it unchanged.
- paddr/pwdata/pwrite hold their values between transfers; psel/penable return to 0.
- newd while busy_o=1 is ignored (no queueing).
- newd in the same cycle as done_o is accepted, giving a back-to-back transfer. Minimum transfer = 1 IDLE + SETUP + 1 ACCESS = done_o 3 cycles after newd.
- At most one psel bit is ever high; psel never changes between SETUP and the end of ACCESS.

Test Plan:
- Write, slave 0, pready tied 1: newd=1, wr=1, slv_id=0, addrin=0x10, datain=0xDEADBEEF.
  -> psel=3'b001 for 2 cycles, penable only in the 2nd, paddr=0x10, pwdata=0xDEADBEEF; done_o 3 cycles after newd; slverr_o=0.
- Read, slave 1, 2 wait states: slave returns 0x12345678 with pready on the 3rd ACCESS cycle.
  -> ACCESS lasts 3 cycles; dataout=0x12345678; done_o=1, slverr_o=0.
- Slave error: read of slave 2 with pready=1, pslverr=1, prdata=0xFFFF0000.
  -> slverr_o=1, timeout_o=0, dataout unchanged.
- Decode error: slv_id=3 with NUM_SLAVES=3.
  -> psel stays 0, penable stays 0; done_o 2 cycles after newd; slverr_o=1, timeout_o=0.
- Timeout: slave 0 pready held 0, TIMEOUT=16.
  -> exactly 16 ACCESS cycles, then psel=0; done_o=1, slverr_o=1, timeout_o=1.
- Busy, back-to-back and reset: newd pulses during ACCESS are ignored; newd in the done_o cycle starts the next SETUP; preset asserted mid-ACCESS forces psel, penable, busy_o and done_o to 0 immediately and FSM to IDLE.
